// File: rtl/iir_out_buf_if.sv
// IIR output buffer bus: filter sample input, result-memory write
// port and status outputs, grouped for the buffer and its driver.
interface iir_out_buf_if;
  logic        WEN;
  logic [15:0] Yn;
  logic [19:0] WAddr;
  logic        Finish;
  logic        mem_ready;
  logic        mem_wen;
  logic [19:0] mem_addr;
  logic [15:0] mem_data;
  logic        overflow;
  logic        done;
  logic [19:0] sample_count;
  logic [15:0] peak_max;
  logic [15:0] peak_min;

  modport master (
    output WEN,
    output Yn,
    output WAddr,
    output Finish,
    output mem_ready,
    input  mem_wen,
    input  mem_addr,
    input  mem_data,
    input  overflow,
    input  done,
    input  sample_count,
    input  peak_max,
    input  peak_min
  );

  modport slave (
    input  WEN,
    input  Yn,
    input  WAddr,
    input  Finish,
    input  mem_ready,
    output mem_wen,
    output mem_addr,
    output mem_data,
    output overflow,
    output done,
    output sample_count,
    output peak_max,
    output peak_min
  );
endinterface

// File: rtl/iir_out_buf.sv
// IIR output buffer: FIFO between filter output and result memory,
// with drop detection, end-of-stream sequencing and peak tracking.
module iir_out_buf #(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  iir_out_buf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } entry_t;

  state_t       state_q, state_d;
  entry_t       fifo_q [DEPTH];
  entry_t       fifo_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         mem_wen_q, mem_wen_d;
  logic [19:0]  mem_addr_q, mem_addr_d;
  logic [15:0]  mem_data_q, mem_data_d;
  logic         ovf_q, ovf_d;
  logic [19:0]  scnt_q, scnt_d;
  logic [15:0]  pmax_q, pmax_d;
  logic [15:0]  pmin_q, pmin_d;

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic drop;

  // Handshake qualification; pop sees the pre-push head, so no bypass.
  always_comb begin
    full   = (cnt_q == CW'(DEPTH));
    pop    = (cnt_q != '0) && bus.mem_ready;
    accept = bus.WEN && (state_q != DONE);
    push   = accept && (!full || pop);
    drop   = accept && full && !pop;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = '{addr: bus.WAddr, data: bus.Yn};
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Memory write port: popped entry is presented for one cycle.
  always_comb begin
    mem_wen_d  = pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (pop) begin
      mem_addr_d = fifo_q[rptr_q].addr;
      mem_data_d = fifo_q[rptr_q].data;
    end
  end

  // Statistics: sticky drop flag, saturating count, signed peaks.
  always_comb begin
    ovf_d  = ovf_q | drop;
    scnt_d = scnt_q;
    pmax_d = pmax_q;
    pmin_d = pmin_q;
    if (push) begin
      if (scnt_q != 20'hFFFFF) begin
        scnt_d = scnt_q + 20'd1;
      end
      if ($signed(bus.Yn) > $signed(pmax_q)) begin
        pmax_d = bus.Yn;
      end
      if ($signed(bus.Yn) < $signed(pmin_q)) begin
        pmin_d = bus.Yn;
      end
    end
  end

  // Stream sequencing: DONE once Finish seen and the FIFO has drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (push) begin
          state_d = RUN;
        end else if (bus.Finish) begin
          state_d = DRAIN;
        end
      end
      RUN: begin
        if (bus.Finish) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((cnt_d == '0) && !push) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      ovf_q      <= 1'b0;
      scnt_q     <= '0;
      pmax_q     <= 16'h8000;
      pmin_q     <= 16'h7FFF;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      ovf_q      <= ovf_d;
      scnt_q     <= scnt_d;
      pmax_q     <= pmax_d;
      pmin_q     <= pmin_d;
    end
  end

  // Entry storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_q[i] <= fifo_d[i];
    end
  end

  assign bus.mem_wen      = mem_wen_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.overflow     = ovf_q;
  assign bus.done         = (state_q == DONE);
  assign bus.sample_count = scnt_q;
  assign bus.peak_max     = pmax_q;
  assign bus.peak_min     = pmin_q;

endmodule
